// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and data (D) requesters.
// Ready-based memory handshake, IF anti-starvation and a bus timeout.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_valid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned SC_W = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
  localparam int unsigned TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_owner_d, w_owner_d_nxt;
  logic [SC_W-1:0]   r_starve, w_starve_nxt;
  logic [TC_W-1:0]   r_tcnt, w_tcnt_nxt, w_tcnt_inc;
  logic              r_mask_i, w_mask_i_nxt;
  logic              r_mask_d, w_mask_d_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [BE_W-1:0]   r_mem_be, w_mem_be_nxt;
  logic              r_if_valid, w_if_valid_nxt;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
  logic              r_dm_valid, w_dm_valid_nxt;
  logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata_nxt;
  logic              r_bus_err, w_bus_err_nxt;
  logic              w_grant_i, w_grant_d;

  // A requester masked after its own RESP only yields when alone; contention is
  // always settled by D priority and the starvation limit.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (r_state == S_IDLE) begin
      if (if_req && dm_req) begin
        w_grant_i = (r_starve == SC_W'(MAX_STARVE));
        w_grant_d = ~w_grant_i;
      end else if (if_req && !r_mask_i) begin
        w_grant_i = 1'b1;
      end else if (dm_req && !r_mask_d) begin
        w_grant_d = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_d_nxt   = r_owner_d;
    w_starve_nxt    = r_starve;
    w_tcnt_nxt      = r_tcnt;
    w_tcnt_inc      = r_tcnt + TC_W'(1);
    w_mask_i_nxt    = 1'b0;
    w_mask_d_nxt    = 1'b0;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_be_nxt    = r_mem_be;
    w_if_valid_nxt  = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_dm_valid_nxt  = 1'b0;
    w_dm_rdata_nxt  = r_dm_rdata;
    w_bus_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!if_req || w_grant_i) begin
          w_starve_nxt = '0;
        end else if (w_grant_d && (r_starve != SC_W'(MAX_STARVE))) begin
          w_starve_nxt = r_starve + SC_W'(1);
        end
        if (w_grant_i || w_grant_d) begin
          w_state_nxt   = S_BUSY;
          w_owner_d_nxt = w_grant_d;
          w_tcnt_nxt    = '0;
          w_mem_req_nxt = 1'b1;
          if (w_grant_d) begin
            w_mem_addr_nxt  = dm_addr;
            w_mem_we_nxt    = dm_we;
            w_mem_wdata_nxt = dm_wdata;
            w_mem_be_nxt    = dm_be;
          end else begin
            w_mem_addr_nxt  = if_addr;
            w_mem_we_nxt    = 1'b0;
            w_mem_wdata_nxt = '0;
            w_mem_be_nxt    = '1;
          end
        end
      end
      S_BUSY: begin
        // Ready on the final counted cycle wins over the timeout.
        if (mem_ready) begin
          w_state_nxt   = S_RESP;
          w_mem_req_nxt = 1'b0;
          if (r_owner_d) begin
            w_dm_valid_nxt = 1'b1;
            w_dm_rdata_nxt = r_mem_we ? '0 : mem_rdata;
          end else begin
            w_if_valid_nxt = 1'b1;
            w_if_rdata_nxt = mem_rdata;
          end
        end else if ((TIMEOUT != 0) && (w_tcnt_inc == TC_W'(TIMEOUT))) begin
          w_state_nxt   = S_RESP;
          w_mem_req_nxt = 1'b0;
          w_bus_err_nxt = 1'b1;
          if (r_owner_d) begin
            w_dm_valid_nxt = 1'b1;
            w_dm_rdata_nxt = '0;
          end else begin
            w_if_valid_nxt = 1'b1;
            w_if_rdata_nxt = '0;
          end
        end else begin
          w_tcnt_nxt = w_tcnt_inc;
        end
      end
      S_RESP: begin
        w_state_nxt  = S_IDLE;
        w_mask_i_nxt = ~r_owner_d;
        w_mask_d_nxt = r_owner_d;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= S_IDLE;
      r_owner_d   <= 1'b0;
      r_starve    <= '0;
      r_tcnt      <= '0;
      r_mask_i    <= 1'b0;
      r_mask_d    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_valid  <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_valid  <= 1'b0;
      r_dm_rdata  <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner_d   <= w_owner_d_nxt;
      r_starve    <= w_starve_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_mask_i    <= w_mask_i_nxt;
      r_mask_d    <= w_mask_d_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_dm_valid  <= w_dm_valid_nxt;
      r_dm_rdata  <= w_dm_rdata_nxt;
      r_bus_err   <= w_bus_err_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign if_valid  = r_if_valid;
  assign if_rdata  = r_if_rdata;
  assign dm_valid  = r_dm_valid;
  assign dm_rdata  = r_dm_rdata;
  assign bus_err   = r_bus_err;
  assign stall_if  = if_req & ~r_if_valid;
  assign stall_mem = dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a cycle-timestamp reference of the arbitration and handshake rules.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MAXS = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic if_req, if_valid, dm_req, dm_we, dm_valid;
  logic stall_if, stall_mem, mem_req, mem_we, mem_ready, bus_err;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
  logic [BW-1:0] dm_be, mem_be;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STARVE(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // reference model: one outstanding access described by grant/response cycles
  int free_at, starve, g, resp, last_resp;
  bit busy, own_d, last_d, e_we, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic [BW-1:0] e_be;

  // stimulus controls
  bit auto_i, auto_d, q_i, q_d, q_d_we, fix_rd, mem_prev;
  int pct, mem_mode, noise, mcnt, mdly;
  logic [AW-1:0] q_i_addr, q_d_addr;
  logic [DW-1:0] q_d_wdata, fix_rdata;
  logic [BW-1:0] q_d_be;

  // observations of the DUT
  int rise_cyc, iv_cyc, dv_cyc, err_cyc, mreq_len, cur_len, n_iv, n_dv;
  bit glog[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
  endtask

  task automatic model_clear();
    busy = 1'b0; starve = 0; last_resp = -100; last_d = 1'b0;
    g = 0; resp = -1; free_at = cyc + 1; mem_prev = 1'b0;
  endtask

  task automatic arbitrate();
    bit mi, md, gi, gd;
    mi = !last_d && (last_resp == cyc - 1);
    md = last_d && (last_resp == cyc - 1);
    gi = 1'b0; gd = 1'b0;
    if (if_req && dm_req) begin
      if (starve == MAXS) gi = 1'b1; else gd = 1'b1;
    end else if (if_req && !mi) gi = 1'b1;
    else if (dm_req && !md) gd = 1'b1;
    if (!if_req || gi) starve = 0;
    else if (gd && starve < MAXS) starve++;
    if (gi || gd) begin
      busy = 1'b1; g = cyc; resp = -1; own_d = gd;
      if (gd) begin
        e_addr = dm_addr; e_we = dm_we; e_wdata = dm_wdata; e_be = dm_be;
      end else begin
        e_addr = if_addr; e_we = 1'b0; e_wdata = '0; e_be = '1;
      end
    end
  endtask

  task automatic step();
    bit exp_iv, exp_dv, exp_mreq;
    logic [31:0] rnd;
    @(posedge clk); #1;
    cyc++;
    if (rst_n) rst_n = 1'b0;
    exp_mreq = busy && (cyc > g) && (resp < 0);
    exp_iv = busy && (resp == cyc) && !own_d;
    exp_dv = busy && (resp == cyc) && own_d;
    check_eq("mem_req", 64'(mem_req), 64'(exp_mreq));
    if (exp_mreq) begin
      check_eq("mem_addr", 64'(mem_addr), 64'(e_addr));
      check_eq("mem_we", 64'(mem_we), 64'(e_we));
      check_eq("mem_be", 64'(mem_be), 64'(e_be));
      if (e_we) check_eq("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    end
    check_eq("if_valid", 64'(if_valid), 64'(exp_iv));
    check_eq("dm_valid", 64'(dm_valid), 64'(exp_dv));
    check_eq("bus_err", 64'(bus_err), 64'((exp_iv || exp_dv) && e_err));
    if (exp_iv) check_eq("if_rdata", 64'(if_rdata), 64'(e_rdata));
    if (exp_dv) check_eq("dm_rdata", 64'(dm_rdata), 64'(e_rdata));
    // observe and run the memory responder
    if (mem_req && !mem_prev) begin
      rise_cyc = cyc; glog.push_back(mem_addr[AW-1]); cur_len = 0; mcnt = 0;
      if (mem_mode == -2) mdly = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(4));
      else mdly = mem_mode;
    end else if (mem_req) mcnt++;
    if (mem_req) cur_len++;
    else if (mem_prev) mreq_len = cur_len;
    if (if_valid) begin iv_cyc = cyc; n_iv++; end
    if (dm_valid) begin dv_cyc = cyc; n_dv++; end
    if (bus_err) err_cyc = cyc;
    mem_prev = mem_req;
    if (busy && resp == cyc) begin
      last_d = own_d; last_resp = cyc; busy = 1'b0; free_at = cyc + 1;
    end
    // requesters hold until their valid, then may re-request at once
    if (exp_iv) if_req = 1'b0;
    if (exp_dv) dm_req = 1'b0;
    if (q_i) begin
      if_req = 1'b1; if_addr = q_i_addr; q_i = 1'b0;
    end else if (auto_i && !if_req && int'($urandom_range(99)) < pct) begin
      rnd = $urandom(); if_req = 1'b1; if_addr = {1'b0, rnd[AW-2:2], 2'b00};
    end
    if (q_d) begin
      dm_req = 1'b1; dm_addr = q_d_addr; dm_we = q_d_we; dm_wdata = q_d_wdata;
      dm_be = q_d_be; q_d = 1'b0;
    end else if (auto_d && !dm_req && int'($urandom_range(99)) < pct) begin
      rnd = $urandom(); dm_req = 1'b1; dm_addr = {1'b1, rnd[AW-2:2], 2'b00};
      dm_we = rnd[0]; dm_wdata = $urandom(); dm_be = BW'($urandom());
    end
    if (mem_req) mem_ready = (mdly >= 0) && (mcnt == mdly);
    else mem_ready = (noise == 2) || ((noise == 1) && ($urandom_range(3) == 0));
    mem_rdata = fix_rd ? fix_rdata : $urandom();
    #1;
    check_eq("stall_if", 64'(stall_if), 64'(if_req && !exp_iv));
    check_eq("stall_mem", 64'(stall_mem), 64'(dm_req && !exp_dv));
    // advance the reference with this cycle's inputs
    if (busy && resp < 0 && cyc > g) begin
      if (mem_ready) begin
        resp = cyc + 1; e_err = 1'b0;
        e_rdata = (own_d && e_we) ? '0 : mem_rdata;
      end else if (TMO != 0 && cyc - g == TMO) begin
        resp = cyc + 1; e_err = 1'b1; e_rdata = '0;
      end
    end else if (!busy && cyc >= free_at) begin
      arbitrate();
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b1;
    #1;
    check_eq("rst_mem_req", 64'(mem_req), 64'(0));
    check_eq("rst_if_valid", 64'(if_valid), 64'(0));
    check_eq("rst_dm_valid", 64'(dm_valid), 64'(0));
    check_eq("rst_bus_err", 64'(bus_err), 64'(0));
    model_clear();
  endtask

  task automatic clear_obs();
    rise_cyc = -1000; iv_cyc = -1000; dv_cyc = -1000; mreq_len = -1;
  endtask

  initial begin
    int c0, c1, iv0, dv0, err0;
    rst_n = 1'b1;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_ready = 0; mem_rdata = '0;
    auto_i = 0; auto_d = 0; q_i = 0; q_d = 0; pct = 0; mem_mode = 0; noise = 0; fix_rd = 0;
    mcnt = 0; mdly = 0; cur_len = 0; n_iv = 0; n_dv = 0; err_cyc = -1000;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mem_req", 64'(mem_req), 64'(0));
    check_eq("rst_mem_addr", 64'(mem_addr), 64'(0));
    check_eq("rst_mem_be", 64'(mem_be), 64'(0));
    check_eq("rst_if_valid", 64'(if_valid), 64'(0));
    check_eq("rst_dm_valid", 64'(dm_valid), 64'(0));
    check_eq("rst_bus_err", 64'(bus_err), 64'(0));
    model_clear();

    // single fetch, memory ready held high
    noise = 2; mem_mode = 0;
    q_i = 1; q_i_addr = 32'h0000_0010; c0 = cyc + 1;
    run(6);
    check_eq("a_req_lat", 64'(rise_cyc - c0), 64'(1));
    check_eq("a_valid_lat", 64'(iv_cyc - c0), 64'(2));

    // simultaneous store and fetch
    noise = 0; run(3); clear_obs(); iv0 = n_iv; dv0 = n_dv;
    q_i = 1; q_i_addr = 32'h40;
    q_d = 1; q_d_addr = 32'h100; q_d_we = 1; q_d_wdata = 32'hCAFE_F00D; q_d_be = 4'b0011;
    c0 = cyc + 1;
    run(9);
    check_eq("b_store_lat", 64'(dv_cyc - c0), 64'(2));
    check_eq("b_fetch_lat", 64'(iv_cyc - c0), 64'(5));
    check_eq("b_n_dv", 64'(n_dv - dv0), 64'(1));
    check_eq("b_n_iv", 64'(n_iv - iv0), 64'(1));

    // continuous contention: four data grants then a forced fetch
    run(3); glog.delete();
    auto_i = 1; auto_d = 1; pct = 100;
    run(32);
    auto_i = 0; auto_d = 0;
    run(10);
    check_eq("c_ngrant", 64'(glog.size() >= 10), 64'(1));
    for (int k = 0; k < 10; k++)
      check_eq("c_owner", (k < glog.size()) ? 64'(glog[k]) : 64'(2), 64'((k % 5) != 4));

    // load with delayed ready
    clear_obs(); fix_rd = 1; fix_rdata = 32'h1234_5678; mem_mode = 5;
    q_d = 1; q_d_addr = 32'h200; q_d_we = 0; q_d_wdata = '0; q_d_be = 4'hF; c0 = cyc + 1;
    run(10);
    check_eq("d_valid_lat", 64'(dv_cyc - c0), 64'(7));
    check_eq("d_req_len", 64'(mreq_len), 64'(6));
    fix_rd = 0;

    // timeout, then a normal access
    clear_obs(); mem_mode = -1; q_i = 1; q_i_addr = 32'h80; c0 = cyc + 1;
    run(20);
    check_eq("e_valid_lat", 64'(iv_cyc - c0), 64'(TMO + 1));
    check_eq("e_req_len", 64'(mreq_len), 64'(TMO));
    check_eq("e_err_cyc", 64'(err_cyc), 64'(iv_cyc));
    err0 = err_cyc; mem_mode = 0; q_i = 1; q_i_addr = 32'h84; c1 = cyc + 1;
    run(4);
    check_eq("e_next_lat", 64'(iv_cyc - c1), 64'(2));
    check_eq("e_next_noerr", 64'(err_cyc), 64'(err0));

    // reset during an access, held fetch is served after release
    clear_obs(); mem_mode = -1; q_i = 1; q_i_addr = 32'hC0; iv0 = n_iv;
    run(4);
    pulse_reset();
    c1 = cyc; mem_mode = 0;
    run(5);
    check_eq("f_after_rst", 64'(iv_cyc - c1), 64'(3));
    check_eq("f_n_iv", 64'(n_iv - iv0), 64'(1));

    // random traffic
    iv0 = n_iv; dv0 = n_dv;
    auto_i = 1; auto_d = 1; pct = 30; mem_mode = -2; noise = 1;
    run(3000);
    auto_i = 0; auto_d = 0;
    run(60);
    check_eq("r_activity", 64'((n_iv - iv0) + (n_dv - dv0) > 100), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) requester and data-memory (MEM-stage) requester.
- Sequences each access over a ready-based memory handshake and returns read data to the owning requester.
- Generates stall signals for the IF and MEM stages.
- Includes anti-starvation for IF and a bus timeout.
- Sits between the pipeline core and the memory model, inside the pipelined CPU top.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8 wide)
MAX_STARVE, 4, consecutive data grants allowed while IF waits before IF is forced
TIMEOUT, 16, cycles to wait for mem_ready before aborting; 0 disables timeout

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-high (asserted = 1)
if_req  in  1  fetch request, held until if_valid
if_addr  in  ADDR_W  fetch address
if_valid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DATA_W  fetched word
dm_req  in  1  data request, held until dm_valid
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_be  in  DATA_W/8  store byte enables
dm_valid  out  1  one-cycle pulse, access complete; dm_rdata valid for loads
dm_rdata  out  DATA_W  load data
stall_if  out  1  if_req & ~if_valid (combinational)
stall_mem  out  1  dm_req & ~dm_valid (combinational)
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  write data
mem_be  out  DATA_W/8  byte enables; all ones for fetch
mem_ready  in  1  memory accepted/completed access this cycle
mem_rdata  in  DATA_W  read data, valid with mem_ready
bus_err  out  1  one-cycle pulse alongside valid when a timeout aborted the access

Behaviour:
- Reset values: all registered outputs 0; state IDLE; starve_cnt 0; timeout counter 0.
- Reset mid-access drops mem_req immediately and discards the access; no valid pulse is produced.
- States:
  - IDLE: arbitrate.
  - BUSY: mem_req held, owner latched (I or D).
  - RESP: one cycle; owner valid pulses, then back to IDLE.
- Arbitration (IDLE), per cycle:
  - A requester whose valid pulsed in the previous RESP is masked for that cycle.
  - If both request: D wins unless starve_cnt == MAX_STARVE, in which case I wins.
  - A single requester wins.
  - On a grant, latch addr/we/wdata/be (fetch: we=0, be all ones) into the mem_* registers, set mem_req=1, go to BUSY.
- Latency: request sampled in IDLE at cycle 0 → mem_req=1 at cycle 1. If mem_ready arrives at cycle k, at cycle k+1 the state is RESP with valid=1 and rdata=mem_rdata captured at k. Minimum request-to-valid is 2 cycles when mem_ready is high on the first mem_req cycle.
- mem_req, mem_addr, mem_we, mem_wdata and mem_be are stable throughout BUSY. mem_req falls in the cycle after mem_ready.
- RESP → IDLE; arbitration resumes the cycle after RESP, giving a 1-cycle bubble between back-to-back accesses.
- Store completion also pulses dm_valid; dm_rdata is undefined for stores and is driven to 0.
- starve_cnt:
  - Increments on a D grant while if_req=1.
  - Clears on any I grant, and on any arbitration cycle where if_req=0.
  - Saturates at MAX_STARVE.
- Timeout (TIMEOUT>0):
  - The counter runs in BUSY and clears on entry to BUSY.
  - When it reaches TIMEOUT without mem_ready, drop mem_req and go to RESP.
  - In that RESP, the owner's valid=1, rdata=0, bus_err=1.
  - mem_ready arriving in the same cycle the count hits TIMEOUT counts as success, not an error.
- mem_ready outside BUSY is ignored.
- if_valid and dm_valid are never high in the same cycle.

Test Plan:
- Reset, then if_req=1, if_addr=0x0000_0010, mem_ready tied 1 → mem_req at cycle 1, if_valid at cycle 2 with if_rdata=mem_rdata, stall_if=1 in cycles 0–1.
- Both request at cycle 0 (if_addr=0x40, dm_we=1 dm_addr=0x100 dm_wdata=0xCAFE_F00D dm_be=4'b0011) → store issued first with mem_be=0011; fetch issued after the RESP+IDLE cycles; both valids pulse exactly once.
- dm_req held continuously with if_req=1, MAX_STARVE=4 → 4 data grants, then 1 fetch grant, then data again; starve_cnt returns to 0.
- mem_ready delayed 5 cycles on a load (dm_addr=0x200, mem_rdata=0x1234_5678) → mem_* signals stable for 5 cycles, dm_valid one cycle after mem_ready, dm_rdata=0x1234_5678, bus_err=0.
- mem_ready never asserted, TIMEOUT=16 → mem_req drops after 16 BUSY cycles; owner valid=1, rdata=0, bus_err=1 for one cycle; next request proceeds normally.
- rst_n pulsed high during BUSY → mem_req, valids and bus_err go to 0 immediately; after release, the held if_req is re-arbitrated and served.
